// File: rtl/fir_sched_pkg.sv
// Shared encodings and helpers for the 40-tap, 4-bank FIR coefficient scheduler.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package fir_sched_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_SUM  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int         NUM_BANKS     = 4;
    localparam logic [3:0] TAPS_PER_BANK = 4'd10;
    localparam logic [5:0] MAX_TAPS      = 6'd40;

    // Last bank address swept in RUN.
    localparam logic [3:0] LAST_ADDR = TAPS_PER_BANK - 4'd1;
    // SUM spans three cycles: EnMul tail, EnAcc tail, then the EnAdd pulse.
    localparam logic [3:0] SUM_LAST  = 4'd2;

    // Registered host write, replayed onto the bank pins one cycle later.
    typedef struct packed {
        logic        vld;
        logic [1:0]  bank;
        logic [3:0]  addr;
        logic [15:0] dat;
    } wr_req_t;

    // Bank holding global coefficient k (k/10), valid for k < 40.
    function automatic logic [1:0] tap_bank(input logic [5:0] k);
        if (k >= 6'd30)      return 2'd3;
        else if (k >= 6'd20) return 2'd2;
        else if (k >= 6'd10) return 2'd1;
        else                 return 2'd0;
    endfunction

    // Address of coefficient k inside its bank (k%10), valid for k < 40.
    function automatic logic [3:0] tap_offset(input logic [5:0] k);
        logic [5:0] base;
        case (tap_bank(k))
            2'd3:    base = 6'd30;
            2'd2:    base = 6'd20;
            2'd1:    base = 6'd10;
            default: base = 6'd0;
        endcase
        return 4'(k - base);
    endfunction

endpackage

// File: rtl/fir_tap_mask.sv
// Per-bank valid mask: bank b is live at address a when b*10 + a < N.
// Latency: purely combinational.
// Backpressure: none.
// Ports: addr (bank address 0..9), num_taps (clamped N 0..40), bank_vld (1 = bank reads a real tap).
module fir_tap_mask
    import fir_sched_pkg::*;
(
    input  logic [3:0]           addr,
    input  logic [5:0]           num_taps,
    output logic [NUM_BANKS-1:0] bank_vld
);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        localparam logic [6:0] BASE = 7'(b * int'(TAPS_PER_BANK));
        assign bank_vld[b] = (BASE + {3'b000, addr}) < {1'b0, num_taps};
    end

endmodule

// File: rtl/fir_bank_sched.sv
// Sequences coefficient loads and per-sample bank reads for a 40-tap FIR split over 4 SRAM banks.
// Latency: fixed 14 cycles from sample strobe to oDone, independent of tap count.
// Backpressure: none; strobes arriving while busy are dropped and latch the sticky oOverrun flag.
// Ports: iClk_12M/iRsn clock and async active-high reset; iEnSample_300k sample strobe;
//        iCoeffiUpdateFlag load-mode level; iCsnRam/iWrnRam/iAddrRam/iWrDtRam host write port;
//        iNumOfCoeff tap count; oCsnRam/oWrnRam/oAddrRam/oWrDtRam bank SRAM pins;
//        oEnMul/oEnAcc per-bank datapath enables; oEnAdd/oDone/oBusy/oOverrun status.
module fir_bank_sched
    import fir_sched_pkg::*;
(
    input  logic        iClk_12M,
    input  logic        iRsn,
    input  logic        iEnSample_300k,
    input  logic        iCoeffiUpdateFlag,
    input  logic        iCsnRam,
    input  logic        iWrnRam,
    input  logic [5:0]  iAddrRam,
    input  logic [15:0] iWrDtRam,
    input  logic [5:0]  iNumOfCoeff,
    output logic [3:0]  oCsnRam,
    output logic [3:0]  oWrnRam,
    output logic [3:0]  oAddrRam,
    output logic [15:0] oWrDtRam,
    output logic [3:0]  oEnMul,
    output logic [3:0]  oEnAcc,
    output logic        oEnAdd,
    output logic        oDone,
    output logic        oBusy,
    output logic        oOverrun
);

    logic [2:0]           state_q,   state_d;
    logic [3:0]           cnt_q,     cnt_d;      // bank address in RUN, drain step in SUM
    logic [5:0]           n_q,       n_d;        // clamped tap count, frozen for the sample
    logic [NUM_BANKS-1:0] mul_q,     mul_d;
    logic [NUM_BANKS-1:0] acc_q,     acc_d;
    logic                 overrun_q, overrun_d;
    wr_req_t              wr_q,      wr_d;

    logic [NUM_BANKS-1:0] tap_vld;
    logic [NUM_BANKS-1:0] wr_bank_oh;
    logic                 in_run;
    logic                 host_wr;

    fir_tap_mask u_tap_mask (
        .addr     (cnt_q),
        .num_taps (n_q),
        .bank_vld (tap_vld)
    );

    assign in_run     = (state_q == ST_RUN);
    assign host_wr    = !iCsnRam && !iWrnRam && (iAddrRam < MAX_TAPS);
    assign wr_bank_oh = 4'b0001 << wr_q.bank;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        overrun_d = overrun_q;
        wr_d      = wr_q;
        wr_d.vld  = 1'b0;
        // SRAM read data arrives one cycle after the select; accumulate follows the multiply.
        mul_d     = in_run ? tap_vld : '0;
        acc_d     = mul_q;

        case (state_q)
            ST_IDLE: begin
                if (iCoeffiUpdateFlag) begin
                    state_d = ST_LOAD;
                end else if (iEnSample_300k) begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                    n_d     = (iNumOfCoeff > MAX_TAPS) ? MAX_TAPS : iNumOfCoeff;
                end
            end
            ST_LOAD: begin
                if (!iCoeffiUpdateFlag) state_d = ST_IDLE;
                if (iEnSample_300k)     overrun_d = 1'b1;
                if (host_wr) begin
                    wr_d.vld  = 1'b1;
                    wr_d.bank = tap_bank(iAddrRam);
                    wr_d.addr = tap_offset(iAddrRam);
                    wr_d.dat  = iWrDtRam;
                end
            end
            ST_RUN: begin
                if (iEnSample_300k) overrun_d = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_SUM;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_SUM: begin
                if (iEnSample_300k) overrun_d = 1'b1;
                if (cnt_q == SUM_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (iEnSample_300k) overrun_d = 1'b1;
                // A flag raised mid-sample is honoured only once the result is out.
                state_d = iCoeffiUpdateFlag ? ST_LOAD : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge iClk_12M or posedge iRsn) begin
        if (iRsn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            n_q       <= 6'd0;
            mul_q     <= '0;
            acc_q     <= '0;
            overrun_q <= 1'b0;
            wr_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            mul_q     <= mul_d;
            acc_q     <= acc_d;
            overrun_q <= overrun_d;
            wr_q      <= wr_d;
        end
    end

    // Outputs decode straight from reset-cleared flops, so reset idles the pins without a clock.
    assign oCsnRam  = in_run ? ~tap_vld : (wr_q.vld ? ~wr_bank_oh : 4'hF);
    assign oWrnRam  = wr_q.vld ? ~wr_bank_oh : 4'hF;
    assign oAddrRam = in_run ? cnt_q : (wr_q.vld ? wr_q.addr : 4'd0);
    assign oWrDtRam = wr_q.dat;
    assign oEnMul   = mul_q;
    assign oEnAcc   = acc_q;
    assign oEnAdd   = (state_q == ST_SUM) && (cnt_q == SUM_LAST);
    assign oDone    = (state_q == ST_DONE);
    assign oBusy    = (state_q != ST_IDLE);
    assign oOverrun = overrun_q;

endmodule

// File: tb/tb_fir_bank_sched.sv
// Self-checking bench for fir_bank_sched: randomized loads and samples against a cycle-table model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fir_bank_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        strobe;
    logic        flag;
    logic        csn_in;
    logic        wrn_in;
    logic [5:0]  addr_in;
    logic [15:0] dat_in;
    logic [5:0]  ntaps;
    logic [3:0]  csn;
    logic [3:0]  wrn;
    logic [3:0]  addr;
    logic [15:0] wdat;
    logic [3:0]  en_mul;
    logic [3:0]  en_acc;
    logic        en_add;
    logic        done;
    logic        busy;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;

    // Coefficient image reconstructed from what actually reaches the bank pins.
    logic [15:0] mem [4][10];

    fir_bank_sched dut (
        .iClk_12M          (clk),
        .iRsn              (rst),
        .iEnSample_300k    (strobe),
        .iCoeffiUpdateFlag (flag),
        .iCsnRam           (csn_in),
        .iWrnRam           (wrn_in),
        .iAddrRam          (addr_in),
        .iWrDtRam          (dat_in),
        .iNumOfCoeff       (ntaps),
        .oCsnRam           (csn),
        .oWrnRam           (wrn),
        .oAddrRam          (addr),
        .oWrDtRam          (wdat),
        .oEnMul            (en_mul),
        .oEnAcc            (en_acc),
        .oEnAdd            (en_add),
        .oDone             (done),
        .oBusy             (busy),
        .oOverrun          (overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {csn,wrn,addr,mul,acc,add,done,busy} in cycle t after a strobe in cycle 0.
    function automatic logic [22:0] exp_vec(input int t, input int n);
        int          nn;
        logic [3:0]  e_csn, e_mul, e_acc, e_addr;
        nn     = (n > 40) ? 40 : n;
        e_csn  = 4'hF;
        e_mul  = 4'h0;
        e_acc  = 4'h0;
        e_addr = 4'h0;
        for (int b = 0; b < 4; b++) begin
            if (t >= 1 && t <= 10 && b * 10 + t - 1 < nn) e_csn[b] = 1'b0;
            if (t >= 2 && t <= 11 && b * 10 + t - 2 < nn) e_mul[b] = 1'b1;
            if (t >= 3 && t <= 12 && b * 10 + t - 3 < nn) e_acc[b] = 1'b1;
        end
        if (t >= 1 && t <= 10) e_addr = 4'(t - 1);
        return {e_csn, 4'hF, e_addr, e_mul, e_acc, t == 13, t == 14, t >= 1 && t <= 14};
    endfunction

    // Strobe in cycle 0, then check cycles 1..14; optional extra strobe / flag rise mid-run.
    task automatic run_sample(input int n, input int strobe_at, input int flag_at);
        logic [22:0] obs;
        logic [22:0] expv;
        ntaps  = 6'(n);
        strobe = 1'b1;
        step();
        strobe = 1'b0;
        for (int t = 1; t <= 14; t++) begin
            obs  = {csn, wrn, addr, en_mul, en_acc, en_add, done, busy};
            expv = exp_vec(t, n);
            n_cmp++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL run n=%0d cycle=%0d got=%h want=%h", n, t, obs, expv);
            end
            // Tap count must be frozen at the strobe, so scramble it afterwards.
            ntaps  = 6'($urandom_range(0, 63));
            strobe = (t == strobe_at);
            if (t == flag_at) flag = 1'b1;
            step();
        end
        strobe = 1'b0;
    endtask

    // Expect every output at its reset value.
    task automatic check_idle_pins(input string name);
        logic [38:0] obs;
        obs = {csn, wrn, addr, wdat, en_mul, en_acc, en_add, done, busy};
        n_cmp++;
        if (obs !== {4'hF, 4'hF, 4'h0, 16'h0, 4'h0, 4'h0, 3'b000}) begin
            n_err++;
            $display("FAIL %s pins got=%h want=%h", name, obs, {4'hF, 4'hF, 4'h0, 16'h0, 11'h0});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; strobe = 1'b0; flag = 1'b0; csn_in = 1'b1; wrn_in = 1'b1;
        addr_in = 6'd0; dat_in = 16'd0; ntaps = 6'd0;
        #1;
        check_idle_pins("reset");
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL reset_overrun got=%b want=0", overrun);
        end
        step(); step();
        #2 rst = 1'b0;
        step();
        check_idle_pins("post_reset");
    endtask

    task automatic host_write(input int k, input logic [15:0] d);
        csn_in = 1'b0; wrn_in = 1'b0; addr_in = 6'(k); dat_in = d;
        step();
        csn_in = 1'b1; wrn_in = 1'b1;
    endtask

    task automatic test_load_readback();
        int          order [40];
        int          j, tmp;
        logic [3:0]  want_sel;
        for (int i = 0; i < 40; i++) order[i] = i;
        for (int i = 39; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int b = 0; b < 4; b++) for (int a = 0; a < 10; a++) mem[b][a] = 16'hDEAD;
        flag = 1'b1;
        step();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL load_entry busy got=%b want=1", busy);
        end
        for (int i = 0; i < 40; i++) begin
            host_write(order[i], 16'(order[i] + 1));
            want_sel = ~(4'b0001 << (order[i] / 10));
            for (int b = 0; b < 4; b++)
                if (!csn[b] && !wrn[b]) mem[b][addr] = wdat;
            n_cmp++;
            if ({csn, wrn, addr, wdat} !== {want_sel, want_sel, 4'(order[i] % 10), 16'(order[i] + 1)}) begin
                n_err++;
                $display("FAIL load_wr k=%0d got=%h want=%h", order[i], {csn, wrn, addr, wdat},
                         {want_sel, want_sel, 4'(order[i] % 10), 16'(order[i] + 1)});
            end
        end
        host_write($urandom_range(40, 63), 16'hBEEF);
        n_cmp++;
        if ({csn, wrn} !== 8'hFF) begin
            n_err++;
            $display("FAIL load_drop_oob got=%h want=ff", {csn, wrn});
        end
        flag = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL load_exit busy got=%b want=0", busy);
        end
        // Writes outside LOAD must never reach the banks.
        host_write($urandom_range(0, 39), 16'h5A5A);
        n_cmp++;
        if ({csn, wrn} !== 8'hFF) begin
            n_err++;
            $display("FAIL idle_write_ignored got=%h want=ff", {csn, wrn});
        end
        for (int b = 0; b < 4; b++) for (int a = 0; a < 10; a++) begin
            n_cmp++;
            if (mem[b][a] !== 16'(b * 10 + a + 1)) begin
                n_err++;
                $display("FAIL bank_image b=%0d a=%0d got=%h want=%h", b, a, mem[b][a], 16'(b * 10 + a + 1));
            end
        end
        run_sample(40, 0, 0);
    endtask

    task automatic test_tap_counts();
        run_sample(13, 0, 0);
        step();
        run_sample(63, 0, 0);
        run_sample(0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) step();
            run_sample($urandom_range(0, 63), 0, 0);
        end
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL no_overrun got=%b want=0", overrun);
        end
    endtask

    task automatic test_overrun();
        run_sample($urandom_range(1, 40), 5, 0);
        n_cmp++;
        if ({overrun, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL overrun_sticky got=%b want=10", {overrun, busy});
        end
    endtask

    task automatic test_flag_during_run();
        int k;
        run_sample($urandom_range(0, 40), 0, 3);
        n_cmp++;
        if ({busy, csn, wrn} !== {1'b1, 8'hFF}) begin
            n_err++;
            $display("FAIL flag_to_load got=%h want=1ff", {busy, csn, wrn});
        end
        host_write(45, 16'h1234);
        n_cmp++;
        if ({csn, wrn} !== 8'hFF) begin
            n_err++;
            $display("FAIL drop_addr45 got=%h want=ff", {csn, wrn});
        end
        k = $urandom_range(0, 39);
        host_write(k, 16'(k + 1));
        n_cmp++;
        if ({csn, addr} !== {~(4'b0001 << (k / 10)), 4'(k % 10)}) begin
            n_err++;
            $display("FAIL load_after_run k=%0d got=%h want=%h", k, {csn, addr},
                     {~(4'b0001 << (k / 10)), 4'(k % 10)});
        end
        flag = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_run();
        ntaps  = 6'd40;
        strobe = 1'b1;
        step();
        strobe = 1'b0;
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        check_idle_pins("async_reset");
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_overrun got=%b want=0", overrun);
        end
        step();
        #2 rst = 1'b0;
        step();
        run_sample($urandom_range(1, 40), 0, 0);
    endtask

    task automatic test_strobe_in_load();
        flag = 1'b1;
        step();
        strobe = 1'b1;
        step();
        strobe = 1'b0;
        n_cmp++;
        if ({overrun, busy, done, en_mul} !== {3'b110, 4'h0}) begin
            n_err++;
            $display("FAIL strobe_in_load got=%h want=60", {overrun, busy, done, en_mul});
        end
        flag = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_load_readback();
        test_tap_counts();
        test_overrun();
        test_flag_during_run();
        test_reset_mid_run();
        test_strobe_in_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
